// File: rtl/ice_tlx_param_fifo.sv
// Parameterised FIFO: RAM with asynchronous read plus a registered head entry on data_out.
// Define ICE_TLX_FIFO_STICKY_ERR_EN to hold underflow/overflow flags until reset instead of pulsing.
module ice_tlx_param_fifo #(
   parameter int DATA_WIDTH = 6,
   parameter int ADDR_WIDTH = 5,
   parameter int MIN_DEPTH  = 4,
   parameter int AF_MARGIN  = 2
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  wr_enable,
   input  logic                  rd_done,
   input  logic                  use_min_fifo_depth,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  data_available,
   output logic                  data_look_ahead,
   output logic [ADDR_WIDTH:0]   occupancy,
   output logic                  full,
   output logic                  almost_full,
   output logic                  underflow_error,
   output logic                  overflow_error
);

   localparam int                  DEPTH   = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] DEPTH_C = DEPTH[ADDR_WIDTH:0];
   localparam logic [ADDR_WIDTH:0] MIN_C   = MIN_DEPTH[ADDR_WIDTH:0];
   localparam logic [ADDR_WIDTH:0] AF_C    = AF_MARGIN[ADDR_WIDTH:0];
   localparam logic [ADDR_WIDTH:0] CNT_ONE = (ADDR_WIDTH+1)'(1'b1);
   localparam logic [ADDR_WIDTH:0] CNT_ZERO = (ADDR_WIDTH+1)'(1'b0);
   localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1'b1);

   logic [DATA_WIDTH-1:0] mem_r [DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr_r;
   logic [ADDR_WIDTH-1:0] rd_ptr_r;
   logic [ADDR_WIDTH:0]   ram_count_r;
   logic [ADDR_WIDTH:0]   occupancy_r;
   logic [DATA_WIDTH-1:0] head_r;
   logic                  head_valid_r;
   logic                  look_ahead_r;
   logic                  underflow_r;
   logic                  overflow_r;

   logic [ADDR_WIDTH:0]   eff_depth_s;
   logic                  full_s;
   logic                  almost_full_s;
   logic                  pop_s;
   logic                  accept_s;
   logic                  ram_nonempty_s;
   logic                  load_s;
   logic                  head_valid_next_s;
   logic [ADDR_WIDTH:0]   ram_count_next_s;
   logic [ADDR_WIDTH:0]   occupancy_next_s;
   logic                  overflow_next_s;
   logic                  underflow_next_s;

   // Flow-control decode: limits, accept/pop qualification and next-state counters.
   always_comb begin
      eff_depth_s       = DEPTH_C;
      full_s            = 1'b0;
      almost_full_s     = 1'b0;
      pop_s             = 1'b0;
      accept_s          = 1'b0;
      ram_nonempty_s    = 1'b0;
      load_s            = 1'b0;
      head_valid_next_s = head_valid_r;
      ram_count_next_s  = ram_count_r;
      occupancy_next_s  = occupancy_r;
      overflow_next_s   = 1'b0;
      underflow_next_s  = 1'b0;

      if (use_min_fifo_depth) begin
         eff_depth_s = MIN_C;
      end else begin
         eff_depth_s = DEPTH_C;
      end

      full_s         = (occupancy_r >= eff_depth_s);
      almost_full_s  = (occupancy_r >= (eff_depth_s - AF_C));
      pop_s          = rd_done & head_valid_r;
      accept_s       = wr_enable & (~full_s | pop_s);
      ram_nonempty_s = (ram_count_r != CNT_ZERO);
      // The head refills from RAM whenever it is empty or leaving this edge.
      load_s         = (~head_valid_r | pop_s) & ram_nonempty_s;

      if (~head_valid_r | pop_s) begin
         head_valid_next_s = ram_nonempty_s;
      end else begin
         head_valid_next_s = 1'b1;
      end

      case ({accept_s, load_s})
         2'b10:   ram_count_next_s = ram_count_r + CNT_ONE;
         2'b01:   ram_count_next_s = ram_count_r - CNT_ONE;
         default: ram_count_next_s = ram_count_r;
      endcase

      case ({accept_s, pop_s})
         2'b10:   occupancy_next_s = occupancy_r + CNT_ONE;
         2'b01:   occupancy_next_s = occupancy_r - CNT_ONE;
         default: occupancy_next_s = occupancy_r;
      endcase

`ifdef ICE_TLX_FIFO_STICKY_ERR_EN
      overflow_next_s  = overflow_r  | (wr_enable & ~accept_s);
      underflow_next_s = underflow_r | (rd_done & ~head_valid_r);
`else
      overflow_next_s  = wr_enable & ~accept_s;
      underflow_next_s = rd_done & ~head_valid_r;
`endif
   end

   // Control state: pointers, counters, head register and error flags.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_r     <= {ADDR_WIDTH{1'b0}};
         rd_ptr_r     <= {ADDR_WIDTH{1'b0}};
         ram_count_r  <= CNT_ZERO;
         occupancy_r  <= CNT_ZERO;
         head_r       <= {DATA_WIDTH{1'b0}};
         head_valid_r <= 1'b0;
         look_ahead_r <= 1'b0;
         underflow_r  <= 1'b0;
         overflow_r   <= 1'b0;
      end else begin
         if (accept_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (load_s) begin
            head_r   <= mem_r[rd_ptr_r];
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         ram_count_r  <= ram_count_next_s;
         occupancy_r  <= occupancy_next_s;
         head_valid_r <= head_valid_next_s;
         look_ahead_r <= head_valid_next_s & (ram_count_next_s != CNT_ZERO);
         underflow_r  <= underflow_next_s;
         overflow_r   <= overflow_next_s;
      end
   end

   // Storage array; contents are meaningless after reset so it carries none.
   always_ff @(posedge clock) begin
      if (accept_s) begin
         mem_r[wr_ptr_r] <= data_in;
      end
   end

   assign data_out        = head_r;
   assign data_available  = head_valid_r;
   assign data_look_ahead = look_ahead_r;
   assign occupancy       = occupancy_r;
   assign full            = full_s;
   assign almost_full     = almost_full_s;
   assign underflow_error = underflow_r;
   assign overflow_error  = overflow_r;

endmodule

// File: tb/tb_ice_tlx_param_fifo.sv
// Scoreboard bench for ice_tlx_param_fifo: queue-based reference model, directed corner cases
// followed by randomized traffic with depth switching and mid-stream resets.
module tb_ice_tlx_param_fifo;

   logic       clock;
   logic       reset_n;
   logic [5:0] data_in;
   logic       wr_enable;
   logic       rd_done;
   logic       use_min_fifo_depth;
   logic [5:0] data_out;
   logic       data_available;
   logic       data_look_ahead;
   logic [5:0] occupancy;
   logic       full;
   logic       almost_full;
   logic       underflow_error;
   logic       overflow_error;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic [5:0] d;
      int         e;
   } ent_t;

   ent_t       mq[$];
   logic [5:0] sb_q[$];
   int         edges;
   logic       ov_m;
   logic       un_m;

   ice_tlx_param_fifo dut (
      .clock              (clock),
      .reset_n            (reset_n),
      .data_in            (data_in),
      .wr_enable          (wr_enable),
      .rd_done            (rd_done),
      .use_min_fifo_depth (use_min_fifo_depth),
      .data_out           (data_out),
      .data_available     (data_available),
      .data_look_ahead    (data_look_ahead),
      .occupancy          (occupancy),
      .full               (full),
      .almost_full        (almost_full),
      .underflow_error    (underflow_error),
      .overflow_error     (overflow_error)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic int eff_m();
      return use_min_fifo_depth ? 4 : 32;
   endfunction

   // The head is presentable once its entry was written at least one edge earlier.
   function automatic bit front_avail();
      return (mq.size() > 0) && (mq[0].e < edges);
   endfunction

   function automatic bit model_acc();
      return wr_enable && ((mq.size() < eff_m()) || (rd_done && front_avail()));
   endfunction

   // Reference model: an ordered list of stored entries tagged with their write edge.
   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         mq.delete();
         sb_q.delete();
         edges <= 0;
         ov_m  <= 1'b0;
         un_m  <= 1'b0;
      end else begin
`ifdef ICE_TLX_FIFO_STICKY_ERR_EN
         ov_m <= ov_m | (wr_enable && !model_acc());
         un_m <= un_m | (rd_done && !front_avail());
`else
         ov_m <= wr_enable && !model_acc();
         un_m <= rd_done && !front_avail();
`endif
         if (model_acc()) begin
            mq.push_back('{d: data_in, e: edges + 1});
            sb_q.push_back(data_in);
         end
         if (rd_done && front_avail()) begin
            void'(mq.pop_front());
         end
         edges <= edges + 1;
      end
   end

   // Monitor: compares every output mid-cycle and scores each popped head against the write stream.
   always @(negedge clock) begin
      if (!reset_n) begin
         chk("rst_occupancy", 32'(occupancy), 32'd0);
         chk("rst_avail", 32'(data_available), 32'd0);
         chk("rst_full", 32'(full), 32'd0);
         chk("rst_data_out", 32'(data_out), 32'd0);
      end else begin
         chk("occupancy", 32'(occupancy), 32'(mq.size()));
         chk("full", 32'(full), 32'(mq.size() >= eff_m()));
         chk("almost_full", 32'(almost_full), 32'(mq.size() >= eff_m() - 2));
         chk("data_available", 32'(data_available), 32'(front_avail()));
         chk("look_ahead", 32'(data_look_ahead), 32'(front_avail() && mq.size() >= 2));
         chk("overflow_error", 32'(overflow_error), 32'(ov_m));
         chk("underflow_error", 32'(underflow_error), 32'(un_m));
         if (front_avail()) begin
            chk("head_data", 32'(data_out), 32'(mq[0].d));
         end
         if (data_available === 1'b1 && rd_done === 1'b1) begin
            if (sb_q.size() == 0) begin
               chk("pop_without_entry", 32'(sb_q.size()), 32'd1);
            end else begin
               chk("pop_data", 32'(data_out), 32'(sb_q.pop_front()));
            end
         end
      end
   end

   task automatic cycle(input bit w, input logic [5:0] d, input bit r);
      wr_enable = w;
      data_in   = d;
      rd_done   = r;
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      wr_enable = 1'b0;
      rd_done   = 1'b0;
      reset_n   = 1'b0;
      #1;
      chk("async_rst_occupancy", 32'(occupancy), 32'd0);
      chk("async_rst_avail", 32'(data_available), 32'd0);
      chk("async_rst_look_ahead", 32'(data_look_ahead), 32'd0);
      chk("async_rst_data_out", 32'(data_out), 32'd0);
      chk("async_rst_errors", 32'({underflow_error, overflow_error}), 32'd0);
      @(posedge clock);
      #1;
      reset_n = 1'b1;
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while (mq.size() > 0 && guard < 100) begin
         cycle(1'b0, 6'd0, 1'b1);
         guard++;
      end
      chk("drain_bound", 32'(mq.size()), 32'd0);
   endtask

   initial begin
      reset_n            = 1'b0;
      wr_enable          = 1'b0;
      rd_done            = 1'b0;
      data_in            = 6'd0;
      use_min_fifo_depth = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      reset_n = 1'b1;

      // Single write into an empty FIFO: visible two edges later.
      cycle(1'b1, 6'h2A, 1'b0);
      chk("lat_avail_edge1", 32'(data_available), 32'd0);
      cycle(1'b0, 6'h00, 1'b0);
      chk("lat_avail_edge2", 32'(data_available), 32'd1);
      chk("lat_data", 32'(data_out), 32'h2A);
      chk("lat_occupancy", 32'(occupancy), 32'd1);
      drain();

      // Fill to full, then one write too many.
      do_reset();
      for (int i = 0; i < 32; i++) cycle(1'b1, 6'(i), 1'b0);
      chk("fill_full", 32'(full), 32'd1);
      chk("fill_occupancy", 32'(occupancy), 32'd32);
      cycle(1'b1, 6'h3F, 1'b0);
      chk("overflow_flag", 32'(overflow_error), 32'd1);
      chk("overflow_head_kept", 32'(data_out), 32'd0);

      // Full FIFO streaming write+pop across the pointer wrap.
      for (int i = 0; i < 40; i++) cycle(1'b1, 6'(32 + i), 1'b1);
      chk("stream_occupancy", 32'(occupancy), 32'd32);
      drain();

      // Pop from empty.
      cycle(1'b0, 6'd0, 1'b1);
      chk("underflow_flag", 32'(underflow_error), 32'd1);
      chk("underflow_occupancy", 32'(occupancy), 32'd0);
      cycle(1'b0, 6'd0, 1'b0);

      // Shrinking effective depth below the current fill level.
      do_reset();
      for (int i = 0; i < 10; i++) cycle(1'b1, 6'(i + 5), 1'b0);
      cycle(1'b0, 6'd0, 1'b0);
      use_min_fifo_depth = 1'b1;
      #1;
      chk("min_depth_full", 32'(full), 32'd1);
      for (int i = 0; i < 7; i++) cycle(1'b0, 6'd0, 1'b1);
      chk("min_depth_full_at3", 32'(full), 32'd0);
      chk("min_depth_af_at3", 32'(almost_full), 32'd1);
      use_min_fifo_depth = 1'b0;
      drain();

      // Reset mid-stream with 5 entries held.
      for (int i = 0; i < 5; i++) cycle(1'b1, 6'(i + 20), 1'b0);
      do_reset();
      cycle(1'b1, 6'h15, 1'b0);
      cycle(1'b0, 6'h00, 1'b0);
      chk("post_rst_avail", 32'(data_available), 32'd1);
      chk("post_rst_data", 32'(data_out), 32'h15);
      drain();

      // Randomized traffic with shifting write/read bias.
      begin
         int pw;
         int pr;
         pw = 50;
         pr = 50;
         for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) begin
               pw = $urandom_range(10, 95);
               pr = $urandom_range(10, 95);
            end
            if ($urandom_range(0, 49) == 0) use_min_fifo_depth = ~use_min_fifo_depth;
            if ($urandom_range(0, 599) == 0) begin
               do_reset();
            end else begin
               cycle($urandom_range(0, 99) < pw, 6'($urandom), $urandom_range(0, 99) < pr);
            end
         end
      end

      use_min_fifo_depth = 1'b0;
      drain();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
